// File: rtl/eth_rx_stats_gen_if.sv
// Byte-wide AXI4-Stream RX bus as seen by a passive monitor (no tready).
interface eth_rx_stats_gen_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser);
  modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface

// File: rtl/eth_rx_stats_gen.sv
// Per-frame RX statistics vector generator for a byte-wide AXI4-Stream path.
// Watches the stream without backpressure and emits a 28-bit vector with a
// one-cycle strobe in the cycle after each tlast beat.
module eth_rx_stats_gen #(
  parameter int MAX_FRAME_SIZE = 1522,
  parameter int MIN_FRAME_SIZE = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  eth_rx_stats_gen_if.slave   s_axis,
  output logic [27:0]         rx_stats_vector,
  output logic                rx_stats_valid
);

  typedef enum logic {IDLE, FRAME} state_t;

  state_t      state;
  logic [15:0] idx;
  logic        mc;
  logic        bc;
  logic        vlan;
  logic        ctrl;
  logic [7:0]  b12;

  logic [15:0] cur;
  logic        mc_n;
  logic        bc_n;
  logic        vlan_n;
  logic        ctrl_n;
  logic [16:0] len;
  logic [13:0] len_f;
  logic        too_long;
  logic        too_short;
  logic        bad;
  logic        good;
  logic        bc_f;
  logic        mc_f;

  // Header flags and classification for the beat currently on the bus.
  always_comb begin
    cur    = (state == IDLE) ? '0 : idx;
    mc_n   = mc;
    bc_n   = bc;
    vlan_n = vlan;
    ctrl_n = ctrl;
    if (cur == 16'd0) begin
      mc_n = s_axis.tdata[0];
      bc_n = (s_axis.tdata == 8'hFF);
    end else if (cur < 16'd6) begin
      bc_n = bc & (s_axis.tdata == 8'hFF);
    end
    if (cur == 16'd13) begin
      vlan_n = ({b12, s_axis.tdata} == 16'h8100);
      ctrl_n = ({b12, s_axis.tdata} == 16'h8808);
    end
    len       = {1'b0, cur} + 17'd1;
    len_f     = (len > 17'd16383) ? '1 : len[13:0];
    too_long  = (len > 17'(MAX_FRAME_SIZE));
    too_short = (len < 17'(MIN_FRAME_SIZE));
    bad       = s_axis.tuser;
    good      = !bad && !too_long && !too_short;
    // Broadcast needs all six destination bytes; it always implies multicast.
    bc_f      = bc_n && (cur >= 16'd5);
    mc_f      = mc_n | bc_f;
  end

  // Frame FSM, byte counter, header capture and registered stats output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      idx             <= '0;
      mc              <= 1'b0;
      bc              <= 1'b0;
      vlan            <= 1'b0;
      ctrl            <= 1'b0;
      b12             <= '0;
      rx_stats_vector <= '0;
      rx_stats_valid  <= 1'b0;
    end else begin
      rx_stats_valid <= 1'b0;
      if (s_axis.tvalid) begin
        if (s_axis.tlast) begin
          rx_stats_vector <= {6'b0, len_f, ctrl_n, vlan_n, mc_f, bc_f,
                              too_short, too_long, bad, good};
          rx_stats_valid  <= 1'b1;
          state           <= IDLE;
          idx             <= '0;
          mc              <= 1'b0;
          bc              <= 1'b0;
          vlan            <= 1'b0;
          ctrl            <= 1'b0;
          b12             <= '0;
        end else begin
          state <= FRAME;
          idx   <= (cur == 16'hFFFF) ? cur : cur + 16'd1;
          mc    <= mc_n;
          bc    <= bc_n;
          vlan  <= vlan_n;
          ctrl  <= ctrl_n;
          if (cur == 16'd12) b12 <= s_axis.tdata;
        end
      end
    end
  end

endmodule
